coeff_bank_loader: RTL and testbench



---
 rtl/coeff_bank_pkg.sv | 30 +++
 rtl/coeff_bank_loader_if.sv | 24 ++
 rtl/coeff_lane.sv | 59 +++++
 rtl/coeff_bank_loader.sv | 138 +++++++++++++
 tb/tb_coeff_bank_loader.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/coeff_bank_pkg.sv
// Shared configuration, FSM states and sign-extension helper for the coefficient bank.
// Combinational only; no latency, no backpressure.
package coeff_bank_pkg;

    localparam int BITS = 32;
    localparam int TAPS = 49;
    localparam int CH   = 2;
    localparam int AW   = $clog2(TAPS);
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int MAX  = $clog2(TAPS) + BITS;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SWAP
    } state_e;

    function automatic logic [MAX-1:0] sext(input logic [BITS-1:0] v);
        return {{(MAX-BITS){v[BITS-1]}}, v};
    endfunction

    function automatic logic tap_legal(input logic [AW-1:0] a);
        return (int'(a) < TAPS);
    endfunction

    function automatic logic ch_legal(input logic [CW-1:0] c);
        return (int'(c) < CH);
    endfunction

endpackage

// File: rtl/coeff_bank_loader_if.sv
// Host write/commit port of the coefficient bank.
// No latency of its own; wr_ready is the only backpressure signal.
interface coeff_bank_loader_if;
    import coeff_bank_pkg::*;

    logic            wr_valid;
    logic            wr_ready;
    logic [CW-1:0]   wr_ch;
    logic [AW-1:0]   wr_addr;
    logic [BITS-1:0] wr_data;
    logic            commit;
    logic [CW-1:0]   commit_ch;

    modport master (
        output wr_valid, wr_ch, wr_addr, wr_data, commit, commit_ch,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_ch, wr_addr, wr_data, commit, commit_ch,
        output wr_ready
    );

endinterface

// File: rtl/coeff_lane.sv
// One channel: shadow bank, active bank and the masked, sign-extended coeff register.
// Latency 1 cycle active/tap_en -> coeff; writes are never stalled here.
module coeff_lane
    import coeff_bank_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [BITS-1:0]            wr_data,
    input  logic                       copy,
    input  logic [TAPS-1:0]            tap_en,
    output logic [TAPS-1:0][MAX-1:0]   coeff
`ifdef COEFF_READBACK_EN
    ,
    output logic [TAPS-1:0][BITS-1:0]  shadow
`endif
);

    logic [TAPS-1:0][BITS-1:0] shadow_q, shadow_d;
    logic [TAPS-1:0][BITS-1:0] active_q, active_d;
    logic [TAPS-1:0][MAX-1:0]  coeff_q, coeff_d;
    logic [BITS-1:0]           src;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en) begin
            shadow_d[wr_addr] = wr_data;
        end
        active_d = copy ? shadow_q : active_q;
        coeff_d  = '0;
        src      = '0;
        // Feed coeff from the shadow during the copy so it lands together with swap_done.
        for (int t = 0; t < TAPS; t++) begin
            src = copy ? shadow_q[t] : active_q[t];
            if (t == 0 || tap_en[t]) begin
                coeff_d[t] = sext(src);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '0;
            active_q <= '0;
            coeff_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            coeff_q  <= coeff_d;
        end
    end

    assign coeff = coeff_q;
`ifdef COEFF_READBACK_EN
    assign shadow = shadow_q;
`endif

endmodule

// File: rtl/coeff_bank_loader.sv
// Double-buffered multi-channel FIR coefficient store; COEFF_READBACK_EN adds a shadow read port.
// Latency: commit -> 1-cycle SWAP -> coeff + swap_done; wr_ready low only during SWAP.
module coeff_bank_loader
    import coeff_bank_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset_n,
    coeff_bank_loader_if.slave             host,
    input  logic [CH-1:0][TAPS-1:0]        tap_en,
    output logic [CH-1:0][TAPS-1:0][MAX-1:0] coeff,
    output logic [CH-1:0]                  dirty,
    output logic                           busy,
    output logic                           swap_done,
    output logic                           err_addr
`ifdef COEFF_READBACK_EN
    ,
    input  logic [CW-1:0]                  rd_ch,
    input  logic [AW-1:0]                  rd_addr,
    output logic [BITS-1:0]                rd_data
`endif
);

    state_e          state_q, state_d;
    logic [CW-1:0]   swap_ch_q, swap_ch_d;
    logic [CH-1:0]   dirty_q, dirty_d;
    logic            busy_q, busy_d;
    logic            swap_done_q, swap_done_d;
    logic            err_q, err_d;
    logic            wr_ready;
    logic            wr_acc;
    logic            wr_ok;
    logic            cm_go;

    assign wr_ready      = (state_q != SWAP);
    assign host.wr_ready = wr_ready;
    assign wr_acc        = host.wr_valid && wr_ready;
    assign wr_ok         = wr_acc && tap_legal(host.wr_addr) && ch_legal(host.wr_ch);

    always_comb begin
        state_d     = state_q;
        swap_ch_d   = swap_ch_q;
        dirty_d     = dirty_q;
        err_d       = err_q;
        swap_done_d = (state_q == SWAP);
        cm_go       = 1'b0;

        if (wr_acc && !wr_ok) begin
            err_d = 1'b1;
        end
        if (wr_ok) begin
            dirty_d[host.wr_ch] = 1'b1;
        end

        if (state_q == SWAP) begin
            dirty_d[swap_ch_q] = 1'b0;
            state_d = (dirty_d != '0) ? LOAD : IDLE;
        end else begin
            // dirty_d already reflects a same-cycle write, so it is copied too.
            if (host.commit) begin
                if (!ch_legal(host.commit_ch)) begin
                    err_d = 1'b1;
                end else if (dirty_d[host.commit_ch]) begin
                    cm_go     = 1'b1;
                    swap_ch_d = host.commit_ch;
                end
            end
            if (cm_go) begin
                state_d = SWAP;
            end else begin
                state_d = (dirty_d != '0) ? LOAD : IDLE;
            end
        end
        busy_d = (state_d == SWAP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            swap_ch_q   <= '0;
            dirty_q     <= '0;
            busy_q      <= 1'b0;
            swap_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            swap_ch_q   <= swap_ch_d;
            dirty_q     <= dirty_d;
            busy_q      <= busy_d;
            swap_done_q <= swap_done_d;
            err_q       <= err_d;
        end
    end

    assign dirty     = dirty_q;
    assign busy      = busy_q;
    assign swap_done = swap_done_q;
    assign err_addr  = err_q;

`ifdef COEFF_READBACK_EN
    logic [CH-1:0][TAPS-1:0][BITS-1:0] shadow_all;
    logic [BITS-1:0]                   rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = '0;
        if (tap_legal(rd_addr) && ch_legal(rd_ch)) begin
            rd_data_d = shadow_all[rd_ch][rd_addr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`endif

    for (genvar c = 0; c < CH; c++) begin : g_lane
        coeff_lane u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_en   (wr_ok && (int'(host.wr_ch) == c)),
            .wr_addr (host.wr_addr),
            .wr_data (host.wr_data),
            .copy    ((state_q == SWAP) && (int'(swap_ch_q) == c)),
            .tap_en  (tap_en[c]),
            .coeff   (coeff[c])
`ifdef COEFF_READBACK_EN
            ,
            .shadow  (shadow_all[c])
`endif
        );
    end

endmodule

// File: tb/tb_coeff_bank_loader.sv
// Directed bench for coeff_bank_loader: write/commit/swap, masking, errors, reset during swap.
module tb_coeff_bank_loader;
    import coeff_bank_pkg::*;

    logic                              clk = 1'b0;
    logic                              reset_n;
    logic [CH-1:0][TAPS-1:0]           tap_en;
    logic [CH-1:0][TAPS-1:0][MAX-1:0]  coeff;
    logic [CH-1:0]                     dirty;
    logic                              busy;
    logic                              swap_done;
    logic                              err_addr;
`ifdef COEFF_READBACK_EN
    logic [CW-1:0]                     rd_ch;
    logic [AW-1:0]                     rd_addr;
    logic [BITS-1:0]                   rd_data;
`endif

    int total = 0;
    int bad   = 0;

    coeff_bank_loader_if bus ();

    coeff_bank_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .host      (bus),
        .tap_en    (tap_en),
        .coeff     (coeff),
        .dirty     (dirty),
        .busy      (busy),
        .swap_done (swap_done),
        .err_addr  (err_addr)
`ifdef COEFF_READBACK_EN
        ,
        .rd_ch     (rd_ch),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic v, input int ch, input int addr, input logic [BITS-1:0] d);
        bus.wr_valid = v;
        bus.wr_ch    = CW'(ch);
        bus.wr_addr  = AW'(addr);
        bus.wr_data  = d;
    endtask

    task automatic set_cm(input logic v, input int ch);
        bus.commit    = v;
        bus.commit_ch = CW'(ch);
    endtask

    localparam logic [63:0] NEG2 = 64'h3F_FFFF_FFFE;

    initial begin
        reset_n = 1'b0;
        tap_en  = '1;
        set_wr(1'b0, 0, 0, '0);
        set_cm(1'b0, 0);
`ifdef COEFF_READBACK_EN
        rd_ch   = '0;
        rd_addr = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_coeff03", coeff[0][3], 0);
        check("rst_dirty", dirty, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_addr, 0);
        check("rst_ready", bus.wr_ready, 1);
        reset_n = 1'b1;
        tick();

        // Shadow write must not reach coeff before commit
        set_wr(1'b1, 0, 3, 32'hFFFF_FFFE);
        tick();
        set_wr(1'b0, 0, 0, '0);
        check("t1_dirty", dirty, 2'b01);
        check("t1_hidden", coeff[0][3], 0);
        tick();
        check("t1_hidden2", coeff[0][3], 0);
        set_cm(1'b1, 0);
        tick();
        set_cm(1'b0, 0);
        check("t1_busy", busy, 1);
        check("t1_ready_swap", bus.wr_ready, 0);
        check("t1_coeff_swap", coeff[0][3], 0);
        check("t1_done_early", swap_done, 0);
        tick();
        check("t1_coeff", coeff[0][3], NEG2);
        check("t1_done", swap_done, 1);
        check("t1_dirty_clr", dirty, 0);
        check("t1_busy_clr", busy, 0);
        tick();
        check("t1_done_pulse", swap_done, 0);

        // Tap masking without commit
        tap_en[0][3] = 1'b0;
        tick();
        check("t2_masked", coeff[0][3], 0);
        tap_en[0][3] = 1'b1;
        tick();
        check("t2_unmasked", coeff[0][3], NEG2);
        tap_en[0][0] = 1'b0;
        set_wr(1'b1, 0, 0, 32'd5);
        set_cm(1'b1, 0);
        tick();
        set_wr(1'b0, 0, 0, '0);
        set_cm(1'b0, 0);
        tick();
        check("t2_tap0", coeff[0][0], 5);

        // Same-cycle write+commit, write held across SWAP
        set_wr(1'b1, 1, 5, 32'd7);
        set_cm(1'b1, 1);
        tick();
        set_cm(1'b0, 0);
        set_wr(1'b1, 1, 6, 32'd9);
        check("t3_ready_swap", bus.wr_ready, 0);
        check("t3_busy", busy, 1);
        tick();
        check("t3_coeff15", coeff[1][5], 7);
        check("t3_done", swap_done, 1);
        check("t3_ready", bus.wr_ready, 1);
        check("t3_dirty_pre", dirty, 2'b00);
        tick();
        set_wr(1'b0, 0, 0, '0);
        check("t3_dirty_held", dirty, 2'b10);
        check("t3_coeff16", coeff[1][6], 0);

        // Illegal address, commit to clean channel
        set_wr(1'b1, 0, 49, 32'd1);
        tick();
        set_wr(1'b0, 0, 0, '0);
        check("t4_err", err_addr, 1);
        check("t4_dirty", dirty, 2'b10);
        set_cm(1'b1, 0);
        tick();
        set_cm(1'b0, 0);
        check("t4_clean_busy", busy, 0);
        tick();
        check("t4_clean_done", swap_done, 0);
        check("t4_err_sticky", err_addr, 1);

        // Two dirty channels, commit during SWAP ignored, reset mid-SWAP
        set_wr(1'b1, 0, 7, 32'd3);
        tick();
        set_wr(1'b0, 0, 0, '0);
        check("t5_dirty11", dirty, 2'b11);
        set_cm(1'b1, 0);
        tick();
        set_cm(1'b1, 1);
        check("t5_busy", busy, 1);
        tick();
        set_cm(1'b0, 0);
        check("t5_coeff07", coeff[0][7], 3);
        check("t5_dirty10", dirty, 2'b10);
        tick();
        check("t5_no_queue", busy, 0);
        check("t5_coeff16", coeff[1][6], 0);
        set_cm(1'b1, 1);
        tick();
        set_cm(1'b0, 0);
        check("t5_busy2", busy, 1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_coeff03", coeff[0][3], 0);
        check("t5_rst_coeff07", coeff[0][7], 0);
        check("t5_rst_coeff15", coeff[1][5], 0);
        check("t5_rst_dirty", dirty, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_err", err_addr, 0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("t5_abort_coeff16", coeff[1][6], 0);
        check("t5_abort_done", swap_done, 0);

`ifdef COEFF_READBACK_EN
        set_wr(1'b1, 1, 48, 32'h1234);
        tick();
        set_wr(1'b0, 0, 0, '0);
        rd_ch   = 1'b1;
        rd_addr = AW'(48);
        tick();
        check("t6_rd", rd_data, 32'h1234);
        check("t6_coeff", coeff[1][48], 0);
        rd_addr = AW'(49);
        tick();
        check("t6_rd_illegal", rd_data, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
